axi4_mem_slave: RTL and testbench

AXI4 memory slave that is the DUT driven by the AXI4 SV/SVA bench. It accepts single-ID INCR bursts on the write channels (AW/W/B) and read channels (AR/R), and stores 32-bit words in an internal array. Error cases return SLVERR: out-of-range address, 4 KB boundary crossing, unsupported size, and WLAST protocol errors.

---
 rtl/axi4_pkg.sv | 37 +++
 rtl/axi4_mem_array.sv | 28 ++
 rtl/axi4_mem_slave.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared types, constants and the burst legality check for the AXI4 memory slave.
package axi4_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    localparam int         BYTES_PER_BEAT = 4;
    localparam logic [2:0] SIZE_32        = 3'd2;
    localparam int         BOUNDARY_4K    = 4096;

    // A burst is illegal when it starts outside memory, runs past the 4 KB
    // page it starts in, or uses a beat size other than 32 bits.
    function automatic logic burst_err(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [31:0] limit
    );
        logic [31:0] end_off;
        end_off = {20'd0, addr[11:0]} + ({24'd0, len} + 32'd1) * 32'(BYTES_PER_BEAT);
        return (addr >= limit) || (end_off > 32'(BOUNDARY_4K)) || (size != SIZE_32);
    endfunction

endpackage

// File: rtl/axi4_mem_array.sv
// Word-addressed storage: one synchronous write port, one combinational read
// port. Contents are deliberately not reset.
module axi4_mem_array #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 1024,
    parameter int IDX_W        = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [MEMORY_DEPTH];

    // Store one word per enabled write cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // An unregistered read returns the pre-write value on a same-cycle collision.
    assign rdata = mem_r[raddr];

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 memory slave: single-ID INCR bursts, independent read and write FSMs,
// SLVERR on illegal bursts and on WLAST misplacement. All outputs registered.
module axi4_mem_slave
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  WLAST,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RLAST
);

    localparam int          IDX_W      = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(MEMORY_DEPTH * BYTES_PER_BEAT);

    // Bursts that would wrap the word index are always flagged as errors and
    // never touch memory, so the burst pointers only need word-index width.

    // ---------------- write channel ----------------
    wstate_t          w_state_r, w_state_s;
    logic [IDX_W-1:0] w_idx_r;
    logic [7:0]       w_len_r, w_cnt_r;
    logic             w_err_r, w_lerr_r;
    logic             aw_hs_s, w_hs_s, b_hs_s, w_end_s, w_lerr_beat_s, w_we_s;
    logic             awready_s, wready_s, bvalid_s;
    logic [1:0]       bresp_s;

    assign aw_hs_s       = AWVALID && AWREADY;
    assign w_hs_s        = WVALID && WREADY;
    assign b_hs_s        = BVALID && BREADY;
    assign w_end_s       = w_hs_s && ((w_cnt_r == w_len_r) || WLAST);
    assign w_lerr_beat_s = WLAST != (w_cnt_r == w_len_r);
    assign w_we_s        = w_hs_s && !w_err_r && !ARESET;

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_state_s;
        end
    end

    // Write FSM next-state decode.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) w_state_s = W_DATA;
                else         w_state_s = W_IDLE;
            end
            W_DATA: begin
                if (w_end_s) w_state_s = W_RESP;
                else         w_state_s = W_DATA;
            end
            W_RESP: begin
                if (b_hs_s) w_state_s = W_IDLE;
                else        w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write channel output decode; registered below so outputs follow the state.
    always_comb begin
        awready_s = (w_state_s == W_IDLE);
        wready_s  = (w_state_s == W_DATA);
        bvalid_s  = (w_state_s == W_RESP);
        bresp_s   = RESP_OKAY;
        if ((w_state_r == W_DATA) && w_end_s) begin
            bresp_s = (w_err_r || w_lerr_r || w_lerr_beat_s) ? RESP_SLVERR : RESP_OKAY;
        end else if (w_state_s == W_RESP) begin
            bresp_s = BRESP;
        end else begin
            bresp_s = RESP_OKAY;
        end
    end

    // Write channel output registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= 2'b00;
        end else begin
            AWREADY <= awready_s;
            WREADY  <= wready_s;
            BVALID  <= bvalid_s;
            BRESP   <= bresp_s;
        end
    end

    // Write burst bookkeeping: capture on AW, advance on each W beat.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_idx_r  <= '0;
            w_len_r  <= 8'd0;
            w_cnt_r  <= 8'd0;
            w_err_r  <= 1'b0;
            w_lerr_r <= 1'b0;
        end else if (aw_hs_s) begin
            w_idx_r  <= AWADDR[IDX_W+1:2];
            w_len_r  <= AWLEN;
            w_cnt_r  <= 8'd0;
            w_err_r  <= burst_err(32'(AWADDR), AWLEN, AWSIZE, ADDR_LIMIT);
            w_lerr_r <= 1'b0;
        end else if (w_hs_s) begin
            w_idx_r  <= w_idx_r + IDX_W'(1);
            w_cnt_r  <= w_cnt_r + 8'd1;
            w_lerr_r <= w_lerr_r | w_lerr_beat_s;
        end
    end

    // ---------------- read channel ----------------
    rstate_t               r_state_r, r_state_s;
    logic [IDX_W-1:0]      r_idx_r, r_idx_nxt_s, mem_raddr_s;
    logic [7:0]            r_len_r, r_cnt_r;
    logic                  r_err_r, ar_err_s;
    logic                  ar_hs_s, r_hs_s, r_last_beat_s;
    logic                  arready_s, rvalid_s, rlast_s;
    logic [1:0]            rresp_s;
    logic [DATA_WIDTH-1:0] rdata_s, mem_rdata_s;

    assign ar_hs_s       = ARVALID && ARREADY;
    assign r_hs_s        = RVALID && RREADY;
    assign r_last_beat_s = (r_cnt_r == r_len_r);
    assign ar_err_s      = burst_err(32'(ARADDR), ARLEN, ARSIZE, ADDR_LIMIT);
    assign r_idx_nxt_s   = r_idx_r + IDX_W'(1);

    // Read port address: the burst start while idle, the next word mid-burst.
    always_comb begin
        if (r_state_r == R_IDLE) begin
            mem_raddr_s = ARADDR[IDX_W+1:2];
        end else begin
            mem_raddr_s = r_idx_nxt_s;
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_state_s;
        end
    end

    // Read FSM next-state decode.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_s = R_DATA;
                else         r_state_s = R_IDLE;
            end
            R_DATA: begin
                if (r_hs_s && r_last_beat_s) r_state_s = R_IDLE;
                else                         r_state_s = R_DATA;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read channel output decode; R payload holds while the master stalls.
    always_comb begin
        arready_s = (r_state_s == R_IDLE);
        rvalid_s  = (r_state_s == R_DATA);
        rdata_s   = RDATA;
        rresp_s   = RRESP;
        rlast_s   = RLAST;
        if ((r_state_r == R_IDLE) && ar_hs_s) begin
            rdata_s = ar_err_s ? '0 : mem_rdata_s;
            rresp_s = ar_err_s ? RESP_SLVERR : RESP_OKAY;
            rlast_s = (ARLEN == 8'd0);
        end else if ((r_state_r == R_DATA) && r_hs_s && !r_last_beat_s) begin
            rdata_s = r_err_r ? '0 : mem_rdata_s;
            rlast_s = ((r_cnt_r + 8'd1) == r_len_r);
        end else if ((r_state_r == R_DATA) && r_hs_s) begin
            rdata_s = '0;
            rresp_s = RESP_OKAY;
            rlast_s = 1'b0;
        end else begin
            rdata_s = RDATA;
        end
    end

    // Read channel output registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= 2'b00;
            RLAST   <= 1'b0;
        end else begin
            ARREADY <= arready_s;
            RVALID  <= rvalid_s;
            RDATA   <= rdata_s;
            RRESP   <= rresp_s;
            RLAST   <= rlast_s;
        end
    end

    // Read burst bookkeeping: capture on AR, advance on each accepted beat.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_idx_r <= '0;
            r_len_r <= 8'd0;
            r_cnt_r <= 8'd0;
            r_err_r <= 1'b0;
        end else if (ar_hs_s) begin
            r_idx_r <= ARADDR[IDX_W+1:2];
            r_len_r <= ARLEN;
            r_cnt_r <= 8'd0;
            r_err_r <= ar_err_s;
        end else if (r_hs_s && !r_last_beat_s) begin
            r_idx_r <= r_idx_nxt_s;
            r_cnt_r <= r_cnt_r + 8'd1;
        end
    end

    axi4_mem_array #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .IDX_W        (IDX_W)
    ) u_mem (
        .clk   (ACLK),
        .we    (w_we_s),
        .waddr (w_idx_r),
        .wdata (WDATA),
        .raddr (mem_raddr_s),
        .rdata (mem_rdata_s)
    );

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed self-checking bench for axi4_mem_slave.
module tb_axi4_mem_slave;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MD = 1024;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic          AWVALID, AWREADY;
    logic [DW-1:0] WDATA;
    logic          WVALID, WREADY, WLAST;
    logic [1:0]    BRESP;
    logic          BVALID, BREADY;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic          ARVALID, ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID, RREADY, RLAST;

    axi4_mem_slave #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MEMORY_DEPTH (MD)
    ) dut (
        .ACLK    (ACLK),    .ARESET  (ARESET),
        .AWADDR  (AWADDR),  .AWLEN   (AWLEN),   .AWSIZE  (AWSIZE),
        .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA   (WDATA),   .WVALID  (WVALID),  .WREADY  (WREADY), .WLAST (WLAST),
        .BRESP   (BRESP),   .BVALID  (BVALID),  .BREADY  (BREADY),
        .ARADDR  (ARADDR),  .ARLEN   (ARLEN),   .ARSIZE  (ARSIZE),
        .ARVALID (ARVALID), .ARREADY (ARREADY),
        .RDATA   (RDATA),   .RRESP   (RRESP),   .RVALID  (RVALID),
        .RREADY  (RREADY),  .RLAST   (RLAST)
    );

    // Free-running 100 MHz clock.
    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [0:31];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_send(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size);
        int cyc;
        AWADDR = addr; AWLEN = len; AWSIZE = size; AWVALID = 1'b1;
        cyc = 0;
        while (!AWREADY && cyc < 20) begin step(); cyc++; end
        check_val("awready_wait", 32'(AWREADY), 32'd1);
        step();
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic last);
        int cyc;
        WDATA = data; WLAST = last; WVALID = 1'b1;
        cyc = 0;
        while (!WREADY && cyc < 20) begin step(); cyc++; end
        check_val("wready_wait", 32'(WREADY), 32'd1);
        step();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    // drop_wlast=1 omits WLAST on every beat; bdelay cycles of BREADY=0 before B accept.
    task automatic w_burst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic drop_wlast, input logic [31:0] base,
                           input int bdelay, input logic [1:0] exp_resp);
        aw_send(addr, len, size);
        for (int b = 0; b <= int'(len); b++) begin
            w_beat(base + 32'(b), !drop_wlast && (b == int'(len)));
            if (b < int'(len)) check_val($sformatf("bvalid_early[%0d]", b), 32'(BVALID), 32'd0);
            else               check_val("bvalid_after_last", 32'(BVALID), 32'd1);
        end
        BREADY = 1'b0;
        if (bdelay > 0) begin
            AWADDR = 16'h0300; AWLEN = 8'd0; AWSIZE = 3'd2; AWVALID = 1'b1;
        end
        for (int d = 0; d < bdelay; d++) begin
            step();
            check_val("bvalid_hold", 32'(BVALID), 32'd1);
            check_val("bresp_hold", 32'(BRESP), 32'(exp_resp));
            check_val("awready_blocked", 32'(AWREADY), 32'd0);
        end
        AWVALID = 1'b0;
        check_val("bresp", 32'(BRESP), 32'(exp_resp));
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check_val("bvalid_drop", 32'(BVALID), 32'd0);
        check_val("awready_back", 32'(AWREADY), 32'd1);
    endtask

    // Expects exp_q[0..len]; toggle alternates RREADY starting low.
    task automatic r_burst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] exp_resp, input logic toggle);
        int   cyc, beats;
        logic hs;
        ARADDR = addr; ARLEN = len; ARSIZE = size; ARVALID = 1'b1;
        cyc = 0;
        while (!ARREADY && cyc < 20) begin step(); cyc++; end
        check_val("arready_wait", 32'(ARREADY), 32'd1);
        step();
        ARVALID = 1'b0;
        beats = 0; cyc = 0;
        while (beats <= int'(len) && cyc < 200) begin
            check_val($sformatf("rvalid[%0d]", beats), 32'(RVALID), 32'd1);
            check_val($sformatf("rdata[%0d]", beats), RDATA, exp_q[beats]);
            check_val($sformatf("rresp[%0d]", beats), 32'(RRESP), 32'(exp_resp));
            check_val($sformatf("rlast[%0d]", beats), 32'(RLAST), 32'(beats == int'(len)));
            RREADY = toggle ? ((cyc % 2) == 1) : 1'b1;
            hs = RVALID && RREADY;
            step();
            cyc++;
            if (hs) beats++;
        end
        RREADY = 1'b0;
        check_val("r_handshakes", 32'(beats), 32'(int'(len) + 1));
        check_val("rvalid_end", 32'(RVALID), 32'd0);
        check_val("arready_back", 32'(ARREADY), 32'd1);
    endtask

    task automatic fill_exp(input logic [31:0] base, input int n, input logic zero);
        for (int i = 0; i < 32; i++) exp_q[i] = 32'd0;
        for (int i = 0; i < n; i++) exp_q[i] = zero ? 32'd0 : base + 32'(i);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_awready"}, 32'(AWREADY), 32'd0);
        check_val({tag, "_wready"},  32'(WREADY),  32'd0);
        check_val({tag, "_bvalid"},  32'(BVALID),  32'd0);
        check_val({tag, "_bresp"},   32'(BRESP),   32'd0);
        check_val({tag, "_arready"}, 32'(ARREADY), 32'd0);
        check_val({tag, "_rvalid"},  32'(RVALID),  32'd0);
        check_val({tag, "_rdata"},   RDATA,        32'd0);
        check_val({tag, "_rresp"},   32'(RRESP),   32'd0);
        check_val({tag, "_rlast"},   32'(RLAST),   32'd0);
    endtask

    // Hard time limit in case a handshake never completes.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed test sequence.
    initial begin
        ARESET = 1'b1;
        AWADDR = 16'h0; AWLEN = 8'd0; AWSIZE = 3'd2; AWVALID = 1'b0;
        WDATA = 32'h0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
        ARADDR = 16'h0; ARLEN = 8'd0; ARSIZE = 3'd2; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        ARESET = 1'b0;
        step();
        check_val("awready_after_reset", 32'(AWREADY), 32'd1);
        check_val("arready_after_reset", 32'(ARREADY), 32'd1);

        // Legal 4-beat write then read back.
        w_burst(16'h0100, 8'd3, 3'd2, 1'b0, 32'h0000_00A0, 0, 2'b00);
        fill_exp(32'h0000_00A0, 4, 1'b0);
        r_burst(16'h0100, 8'd3, 3'd2, 2'b00, 1'b0);

        // Out-of-range address.
        w_burst(16'h5000, 8'd4, 3'd2, 1'b0, 32'h0000_00D0, 0, 2'b10);
        fill_exp(32'h0, 9, 1'b1);
        r_burst(16'h5000, 8'd8, 3'd2, 2'b10, 1'b0);

        // Burst ending exactly at the 4 KB boundary is legal; one crossing it is not.
        w_burst(16'h0FF0, 8'd3, 3'd2, 1'b0, 32'h0000_00E0, 0, 2'b00);
        w_burst(16'h0FF0, 8'd20, 3'd2, 1'b0, 32'h0000_0F00, 0, 2'b10);
        fill_exp(32'h0000_00E0, 4, 1'b0);
        r_burst(16'h0FF0, 8'd3, 3'd2, 2'b00, 1'b0);
        fill_exp(32'h0, 21, 1'b1);
        r_burst(16'h0FF0, 8'd20, 3'd2, 2'b10, 1'b0);

        // Unsupported beat size.
        fill_exp(32'h0, 1, 1'b1);
        r_burst(16'h0100, 8'd0, 3'd1, 2'b10, 1'b0);

        // WLAST never asserted, BREADY held off for 5 cycles.
        w_burst(16'h0100, 8'd4, 3'd2, 1'b1, 32'h0000_00B0, 5, 2'b10);
        fill_exp(32'h0000_00B0, 5, 1'b0);
        r_burst(16'h0100, 8'd4, 3'd2, 2'b00, 1'b0);

        // Out-of-range read with RREADY toggling.
        fill_exp(32'h0, 9, 1'b1);
        r_burst(16'h1500, 8'd8, 3'd2, 2'b10, 1'b1);

        // Reset in the middle of a write burst, on beat 2.
        aw_send(16'h0200, 8'd3, 3'd2);
        w_beat(32'h0000_00C0, 1'b0);
        w_beat(32'h0000_00C1, 1'b0);
        WDATA = 32'h0000_00C2; WVALID = 1'b1; ARESET = 1'b1;
        step();
        check_all_zero("midburst_reset");
        ARESET = 1'b0; WVALID = 1'b0;
        step();
        check_val("awready_after_midreset", 32'(AWREADY), 32'd1);
        repeat (3) begin
            step();
            check_val("no_bvalid_after_reset", 32'(BVALID), 32'd0);
        end
        fill_exp(32'h0000_00C0, 2, 1'b0);
        r_burst(16'h0200, 8'd1, 3'd2, 2'b00, 1'b0);
        fill_exp(32'h0000_00B0, 1, 1'b0);
        r_burst(16'h0100, 8'd0, 3'd2, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
